// File: rtl/lcd16x2_pkg.sv
// Shared constants, instruction classes and cursor-stepping helper for the
// 16x2 LCD bus receiver.
package lcd16x2_pkg;

  localparam int NUM_CELLS = 32;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LAST  = 7'h27;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISPLAY   = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [3:0] {
    INSTR_NOP,
    INSTR_CLEAR,
    INSTR_HOME,
    INSTR_ENTRY,
    INSTR_DISPLAY,
    INSTR_SHIFT,
    INSTR_FUNC_SET,
    INSTR_SET_CGRAM,
    INSTR_SET_DDRAM
  } instr_e;

  // The highest set bit selects the instruction; lower bits are operands.
  function automatic instr_e decode_instr(input logic [7:0] b);
    instr_e kind;
    if      ((b & OP_SET_DDRAM) != 8'h00) kind = INSTR_SET_DDRAM;
    else if ((b & OP_SET_CGRAM) != 8'h00) kind = INSTR_SET_CGRAM;
    else if ((b & OP_FUNC_SET)  != 8'h00) kind = INSTR_FUNC_SET;
    else if ((b & OP_SHIFT)     != 8'h00) kind = INSTR_SHIFT;
    else if ((b & OP_DISPLAY)   != 8'h00) kind = INSTR_DISPLAY;
    else if ((b & OP_ENTRY)     != 8'h00) kind = INSTR_ENTRY;
    else if ((b & OP_HOME)      != 8'h00) kind = INSTR_HOME;
    else if ((b & OP_CLEAR)     != 8'h00) kind = INSTR_CLEAR;
    else                                  kind = INSTR_NOP;
    return kind;
  endfunction

  // Line ends wrap between the two DDRAM lines; 0x7F rolls over to 0x00.
  function automatic logic [6:0] step_cursor(input logic [6:0] addr, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (addr == LINE_LAST)                   nxt = LINE2_BASE;
      else if (addr == (LINE2_BASE + LINE_LAST)) nxt = LINE1_BASE;
      else                                     nxt = addr + 7'd1;
    end else begin
      if (addr == LINE1_BASE)      nxt = LINE2_BASE + LINE_LAST;
      else if (addr == LINE2_BASE) nxt = LINE_LAST;
      else                         nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd16x2_bus_receiver_if.sv
// LCD parallel write bus (RS, E, 8-bit data) as driven by an LCD driver.
interface lcd16x2_bus_receiver_if;

  logic       lcd_rs_i;
  logic       lcd_e_i;
  logic [7:0] lcd_databus_i;

  modport master (output lcd_rs_i, lcd_e_i, lcd_databus_i);
  modport slave  (input  lcd_rs_i, lcd_e_i, lcd_databus_i);

endinterface

// File: rtl/lcd16x2_input_sync.sv
// SYNC_STAGES-deep synchronizer for the 10 LCD bus bits with E falling-edge
// detect; the captured RS/data are the values seen in the last E-high cycle.
module lcd16x2_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rs_i,
  input  logic       e_i,
  input  logic [7:0] data_i,
  output logic       e_high_o,
  output logic       e_fall_o,
  output logic       rs_o,
  output logic [7:0] data_o
);

  logic [9:0]             stage_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [9:0]             prev_q;
  logic                   armed_q;
  logic                   sync_e;

  assign sync_e = stage_q[SYNC_STAGES-1][9];

  // Edges are only honoured once a genuine low E has passed through the
  // chain after reset, so a pulse already in flight at reset is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
      fill_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      stage_q[0] <= {e_i, rs_i, data_i};
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= stage_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !sync_e) armed_q <= 1'b1;
    end
  end

  assign e_high_o = armed_q & sync_e;
  assign e_fall_o = armed_q & prev_q[9] & ~sync_e;
  assign rs_o     = prev_q[8];
  assign data_o   = prev_q[7:0];

endmodule

// File: rtl/lcd16x2_bus_receiver.sv
// HD44780-style bus receiver keeping a 32-cell shadow of visible DDRAM.
// Optional E-width check enabled by defining LCD_RX_TIMING_CHECK_EN.
module lcd16x2_bus_receiver
  import lcd16x2_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int MIN_E_HIGH_CYCLES = 29
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lcd16x2_bus_receiver_if.slave bus,
  output logic                  byte_valid_o,
  output logic [7:0]            byte_o,
  output logic                  rs_o,
  output logic [6:0]            cursor_addr_o,
  output logic                  entry_inc_o,
  output logic                  display_on_o,
  input  logic [4:0]            rd_addr_i,
  output logic [7:0]            rd_char_o,
  output logic                  timing_err_o
);

  logic       e_high;
  logic       e_fall;
  logic       cap_rs;
  logic [7:0] cap_data;
  logic [7:0] cells [NUM_CELLS];
  logic       cell_hit;
  logic [4:0] cell_idx;

  lcd16x2_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rs_i     (bus.lcd_rs_i),
    .e_i      (bus.lcd_e_i),
    .data_i   (bus.lcd_databus_i),
    .e_high_o (e_high),
    .e_fall_o (e_fall),
    .rs_o     (cap_rs),
    .data_o   (cap_data)
  );

  // Only 0x00-0x0F and 0x40-0x4F map onto visible cells.
  always_comb begin
    cell_hit = (cursor_addr_o[6:4] == 3'b000) || (cursor_addr_o[6:4] == 3'b100);
    cell_idx = {cursor_addr_o[6], cursor_addr_o[3:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= BLANK_CHAR;
      cursor_addr_o <= LINE1_BASE;
      entry_inc_o   <= 1'b1;
      display_on_o  <= 1'b0;
      byte_o        <= 8'h00;
      rs_o          <= 1'b0;
      byte_valid_o  <= 1'b0;
      rd_char_o     <= BLANK_CHAR;
    end else begin
      byte_valid_o <= e_fall;
      rd_char_o    <= cells[rd_addr_i];
      if (e_fall) begin
        byte_o <= cap_data;
        rs_o   <= cap_rs;
        if (cap_rs) begin
          if (cell_hit) cells[cell_idx] <= cap_data;
          cursor_addr_o <= step_cursor(cursor_addr_o, entry_inc_o);
        end else begin
          case (decode_instr(cap_data))
            INSTR_SET_DDRAM: cursor_addr_o <= cap_data[6:0];
            INSTR_DISPLAY:   display_on_o  <= cap_data[2];
            INSTR_ENTRY:     entry_inc_o   <= cap_data[1];
            INSTR_HOME:      cursor_addr_o <= LINE1_BASE;
            INSTR_CLEAR: begin
              for (int i = 0; i < NUM_CELLS; i++) cells[i] <= BLANK_CHAR;
              cursor_addr_o <= LINE1_BASE;
              entry_inc_o   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD_RX_TIMING_CHECK_EN
  localparam int CNT_W = $clog2(MIN_E_HIGH_CYCLES + 1);

  logic [CNT_W-1:0] e_high_cnt;
  logic             timing_err_q;

  // Width counter saturates at the minimum; a short pulse still gets captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_high_cnt   <= '0;
      timing_err_q <= 1'b0;
    end else begin
      if (e_high) begin
        if (e_high_cnt != CNT_W'(MIN_E_HIGH_CYCLES)) e_high_cnt <= e_high_cnt + CNT_W'(1);
      end else begin
        e_high_cnt <= '0;
      end
      if (e_fall && (e_high_cnt < CNT_W'(MIN_E_HIGH_CYCLES))) timing_err_q <= 1'b1;
    end
  end

  assign timing_err_o = timing_err_q;
`else
  assign timing_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lcd16x2_bus_receiver.sv
// Directed scoreboard bench for lcd16x2_bus_receiver: stimulus pushes expected
// transfers, a negedge monitor pops and compares on each byte_valid_o pulse.
module tb_lcd16x2_bus_receiver;

  logic       clk;
  logic       rst;
  logic [4:0] rd_addr;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       rs_out;
  logic [6:0] cursor_addr;
  logic       entry_inc;
  logic       display_on;
  logic [7:0] rd_char;
  logic       timing_err;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  lcd16x2_bus_receiver_if bus ();

  lcd16x2_bus_receiver #(.SYNC_STAGES(2), .MIN_E_HIGH_CYCLES(29)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus.slave),
    .byte_valid_o  (byte_valid),
    .byte_o        (byte_out),
    .rs_o          (rs_out),
    .cursor_addr_o (cursor_addr),
    .entry_inc_o   (entry_inc),
    .display_on_o  (display_on),
    .rd_addr_i     (rd_addr),
    .rd_char_o     (rd_char),
    .timing_err_o  (timing_err)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Scoreboard monitor: every captured transfer must match the next expected one.
  always @(negedge clk) begin
    if (!rst && byte_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_byte: got rs=%0b byte=%h, required no transfer", rs_out, byte_out);
      end else begin
        logic [8:0] exp;
        exp = exp_q.pop_front();
        if ({rs_out, byte_out} !== exp) begin
          errors++;
          $display("[TB] FAIL transfer: got rs=%0b byte=%h, required rs=%0b byte=%h",
                   rs_out, byte_out, exp[8], exp[7:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic [7:0] data,
                               input int high_cycles = 40, input int low_cycles = 40);
    exp_q.push_back({rs, data});
    @(negedge clk);
    bus.lcd_rs_i      = rs;
    bus.lcd_databus_i = data;
    bus.lcd_e_i       = 1'b1;
    repeat (high_cycles) @(negedge clk);
    bus.lcd_e_i = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  task automatic checkCell(input int idx, input logic [7:0] expected);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    checkOutput($sformatf("cell%0d", idx), {24'h0, rd_char}, {24'h0, expected});
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    rd_addr           = 5'd0;
    bus.lcd_rs_i      = 1'b0;
    bus.lcd_e_i       = 1'b0;
    bus.lcd_databus_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state and idle sweep");
    checkOutput("reset_rd_char",    {24'h0, rd_char}, 32'h20);
    checkOutput("reset_cursor",     {25'h0, cursor_addr}, 32'h00);
    checkOutput("reset_entry_inc",  {31'h0, entry_inc}, 32'h1);
    checkOutput("reset_display_on", {31'h0, display_on}, 32'h0);
    checkOutput("reset_byte",       {24'h0, byte_out}, 32'h00);
    checkOutput("reset_rs",         {31'h0, rs_out}, 32'h0);
    checkOutput("reset_timing_err", {31'h0, timing_err}, 32'h0);
    for (int i = 0; i < 32; i++) checkCell(i, 8'h20);

    $display("[TB] init sequence and Hello");
    applyStimulus(1'b0, 8'h38);
    applyStimulus(1'b0, 8'h0C);
    applyStimulus(1'b0, 8'h06);
    applyStimulus(1'b0, 8'h01);
    applyStimulus(1'b1, 8'h48);
    applyStimulus(1'b1, 8'h65);
    applyStimulus(1'b1, 8'h6C);
    applyStimulus(1'b1, 8'h6C);
    applyStimulus(1'b1, 8'h6F);
    checkCell(0, 8'h48);
    checkCell(1, 8'h65);
    checkCell(2, 8'h6C);
    checkCell(3, 8'h6C);
    checkCell(4, 8'h6F);
    checkCell(5, 8'h20);
    checkOutput("hello_cursor",     {25'h0, cursor_addr}, 32'h05);
    checkOutput("hello_display_on", {31'h0, display_on}, 32'h1);
    checkOutput("hello_entry_inc",  {31'h0, entry_inc}, 32'h1);

    $display("[TB] line 2 write");
    applyStimulus(1'b0, 8'hC0);
    applyStimulus(1'b1, 8'h57);
    checkCell(16, 8'h57);
    checkOutput("line2_cursor", {25'h0, cursor_addr}, 32'h41);

    $display("[TB] line wrap and decrement");
    applyStimulus(1'b0, 8'hA7);
    applyStimulus(1'b1, 8'h41);
    checkOutput("wrap27_cursor", {25'h0, cursor_addr}, 32'h40);
    checkCell(16, 8'h57);
    checkCell(7, 8'h20);
    applyStimulus(1'b0, 8'h04);
    checkOutput("entry_dec", {31'h0, entry_inc}, 32'h0);
    applyStimulus(1'b1, 8'h58);
    checkOutput("dec40_cursor", {25'h0, cursor_addr}, 32'h27);
    applyStimulus(1'b1, 8'h59);
    checkOutput("dec27_cursor", {25'h0, cursor_addr}, 32'h26);
    checkCell(16, 8'h58);
    checkCell(15, 8'h20);

    $display("[TB] address boundaries");
    applyStimulus(1'b0, 8'h80);
    applyStimulus(1'b1, 8'h31);
    checkOutput("dec00_cursor", {25'h0, cursor_addr}, 32'h67);
    checkCell(0, 8'h31);
    applyStimulus(1'b0, 8'h06);
    applyStimulus(1'b1, 8'h32);
    checkOutput("inc67_cursor", {25'h0, cursor_addr}, 32'h00);
    applyStimulus(1'b0, 8'hFF);
    checkOutput("set7f_cursor", {25'h0, cursor_addr}, 32'h7F);
    applyStimulus(1'b1, 8'h33);
    checkOutput("inc7f_cursor", {25'h0, cursor_addr}, 32'h00);
    checkCell(0, 8'h31);
    applyStimulus(1'b0, 8'hA8);
    applyStimulus(1'b1, 8'h34);
    checkOutput("inc28_cursor", {25'h0, cursor_addr}, 32'h29);

    $display("[TB] ignored and control instructions");
    applyStimulus(1'b0, 8'h40);
    applyStimulus(1'b0, 8'h14);
    applyStimulus(1'b0, 8'h3F);
    checkOutput("ignored_cursor",  {25'h0, cursor_addr}, 32'h29);
    checkOutput("ignored_display", {31'h0, display_on}, 32'h1);
    applyStimulus(1'b0, 8'h08);
    checkOutput("display_off", {31'h0, display_on}, 32'h0);
    applyStimulus(1'b0, 8'h85);
    applyStimulus(1'b0, 8'h00);
    checkOutput("nop_cursor", {25'h0, cursor_addr}, 32'h05);
    applyStimulus(1'b0, 8'h03);
    checkOutput("home_cursor", {25'h0, cursor_addr}, 32'h00);

    $display("[TB] fill and clear");
    applyStimulus(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h2A);
    applyStimulus(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h2A);
    for (int i = 0; i < 32; i++) checkCell(i, 8'h2A);
    applyStimulus(1'b0, 8'h04);
    applyStimulus(1'b0, 8'h01);
    for (int i = 0; i < 32; i++) checkCell(i, 8'h20);
    checkOutput("clear_cursor",    {25'h0, cursor_addr}, 32'h00);
    checkOutput("clear_entry_inc", {31'h0, entry_inc}, 32'h1);

    $display("[TB] reset during E high");
    checkOutput("pending_before_reset", exp_q.size(), 32'd0);
    @(negedge clk);
    bus.lcd_rs_i      = 1'b1;
    bus.lcd_databus_i = 8'h55;
    bus.lcd_e_i       = 1'b1;
    repeat (10) @(negedge clk);
    pulseReset();
    repeat (20) @(negedge clk);
    bus.lcd_e_i = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("rst_mid_byte",   {24'h0, byte_out}, 32'h00);
    checkOutput("rst_mid_cursor", {25'h0, cursor_addr}, 32'h00);
    checkCell(0, 8'h20);
    applyStimulus(1'b1, 8'h33);
    checkCell(0, 8'h33);
    checkOutput("post_rst_cursor", {25'h0, cursor_addr}, 32'h01);

`ifdef LCD_RX_TIMING_CHECK_EN
    $display("[TB] E width check enabled");
    checkOutput("terr_before", {31'h0, timing_err}, 32'h0);
    applyStimulus(1'b1, 8'h61, 10, 40);
    checkOutput("terr_short", {31'h0, timing_err}, 32'h1);
    checkCell(1, 8'h61);
    applyStimulus(1'b1, 8'h62, 40, 40);
    checkOutput("terr_sticky", {31'h0, timing_err}, 32'h1);
    checkCell(2, 8'h62);
    pulseReset();
    checkOutput("terr_reset", {31'h0, timing_err}, 32'h0);
`else
    $display("[TB] E width check absent");
    applyStimulus(1'b1, 8'h61, 10, 40);
    checkOutput("terr_tied_low", {31'h0, timing_err}, 32'h0);
    checkCell(1, 8'h61);
`endif

    repeat (10) @(negedge clk);
    checkOutput("pending_at_end", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
